// File: rtl/psum_ofifo_pkg.sv
// Shared constants for the MAC array output path and a ceil-log2 helper
// used to size FIFO pointers and occupancy counters.
package psum_ofifo_pkg;

   localparam int PSUM_BW = 16;
   localparam int COL     = 8;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// Single-column circular FIFO; a write into a full column survives only when
// a pop frees the head slot in the same cycle, otherwise it is dropped.
module psum_col_fifo
   import psum_ofifo_pkg::*;
#(
   parameter int DW    = PSUM_BW,
   parameter int DEPTH = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_i,
   input  logic [DW-1:0] din_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic          full_o,
   output logic          empty_o,
   output logic [DW-1:0] head_o,
   output logic          drop_o
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          push;

   assign full_o  = (cnt_q == CNT_MAX);
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rptr_q];
   assign push    = wr_i & ~flush_i & (~full_o | pop_i);
   assign drop_o  = wr_i & ~flush_i & full_o & ~pop_i;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push)  wptr_d = wptr_q + PTR_ONE;
         if (pop_i) rptr_d = rptr_q + PTR_ONE;
         if (push && !pop_i)      cnt_d = cnt_q + CNT_ONE;
         else if (!push && pop_i) cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage carries no reset; occupancy is tracked solely by the counters.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= din_i;
   end

endmodule

// File: rtl/psum_ofifo.sv
// Collects skewed per-column psums from the array south edge and releases
// one aligned row per pop once every column holds at least one entry.
module psum_ofifo
   import psum_ofifo_pkg::*;
#(
   parameter int col     = COL,
   parameter int psum_bw = PSUM_BW,
   parameter int depth   = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [col*psum_bw-1:0] in,
   input  logic [col-1:0]         wr,
   input  logic                   rd,
   input  logic                   flush,
   output logic [col*psum_bw-1:0] out,
   output logic                   out_valid,
   output logic                   o_ready,
   output logic                   o_full,
   output logic                   o_empty,
   output logic                   overflow
);

   logic [col-1:0]         full, empty, drop;
   logic [col*psum_bw-1:0] head;
   logic [col*psum_bw-1:0] out_q;
   logic                   out_valid_q, overflow_q;
   logic                   pop;

   assign o_ready = &(~empty);
   assign o_full  = |full;
   assign o_empty = &empty;
   assign pop     = rd & o_ready & ~flush;

   for (genvar c = 0; c < col; c++) begin : g_col
      psum_col_fifo #(
         .DW    (psum_bw),
         .DEPTH (depth)
      ) u_col (
         .clk     (clk),
         .reset   (reset),
         .wr_i    (wr[c]),
         .din_i   (in[c*psum_bw +: psum_bw]),
         .pop_i   (pop),
         .flush_i (flush),
         .full_o  (full[c]),
         .empty_o (empty[c]),
         .head_o  (head[c*psum_bw +: psum_bw]),
         .drop_o  (drop[c])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         out_valid_q <= pop;
         if (pop) out_q <= head;
         if (flush)      overflow_q <= 1'b0;
         else if (|drop) overflow_q <= 1'b1;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo (col=8, psum_bw=16, depth=4): table-driven skewed fill,
// directed corner sequences and randomized traffic against a queue-based model.
module tb_psum_ofifo;

   localparam int C  = 8;
   localparam int BW = 16;
   localparam int D  = 4;

   logic            clk;
   logic            reset;
   logic [C*BW-1:0] in_s;
   logic [C-1:0]    wr;
   logic            rd;
   logic            flush;
   logic [C*BW-1:0] out;
   logic            out_valid, o_ready, o_full, o_empty, overflow;

   psum_ofifo #(.col(C), .psum_bw(BW), .depth(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (in_s),
      .wr        (wr),
      .rd        (rd),
      .flush     (flush),
      .out       (out),
      .out_valid (out_valid),
      .o_ready   (o_ready),
      .o_full    (o_full),
      .o_empty   (o_empty),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: one queue per column plus the registered outputs.
   logic [BW-1:0]   mq [C][$];
   logic [C*BW-1:0] m_out;
   logic            m_ovld, m_ov;

   function automatic logic [C*BW-1:0] rep(input logic [BW-1:0] v);
      return {C{v}};
   endfunction

   task automatic chk(input string name, input logic [C*BW-1:0] act, input logic [C*BW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < C; c++) mq[c].delete();
      m_out  = '0;
      m_ovld = 1'b0;
      m_ov   = 1'b0;
   endtask

   task automatic model_edge(input logic [C-1:0] w, input logic [C*BW-1:0] d,
                             input logic r, input logic f);
      bit ready, pop, full;
      ready = 1'b1;
      for (int c = 0; c < C; c++) if (mq[c].size() == 0) ready = 1'b0;
      pop = r && ready && !f;
      if (f) begin
         for (int c = 0; c < C; c++) mq[c].delete();
         m_ov   = 1'b0;
         m_ovld = 1'b0;
      end else begin
         for (int c = 0; c < C; c++) begin
            full = (mq[c].size() == D);
            if (pop) m_out[c*BW +: BW] = mq[c].pop_front();
            if (w[c]) begin
               if (!full || pop) mq[c].push_back(d[c*BW +: BW]);
               else m_ov = 1'b1;
            end
         end
         m_ovld = pop;
      end
   endtask

   task automatic check_all(input string tag);
      bit e_ready, e_full, e_empty;
      e_ready = 1'b1; e_full = 1'b0; e_empty = 1'b1;
      for (int c = 0; c < C; c++) begin
         if (mq[c].size() == 0) e_ready = 1'b0;
         if (mq[c].size() == D) e_full = 1'b1;
         if (mq[c].size() != 0) e_empty = 1'b0;
      end
      chk({tag, ".out"},       out,       m_out);
      chk({tag, ".out_valid"}, {127'b0, out_valid}, {127'b0, m_ovld});
      chk({tag, ".o_ready"},   {127'b0, o_ready},   {127'b0, e_ready});
      chk({tag, ".o_full"},    {127'b0, o_full},    {127'b0, e_full});
      chk({tag, ".o_empty"},   {127'b0, o_empty},   {127'b0, e_empty});
      chk({tag, ".overflow"},  {127'b0, overflow},  {127'b0, m_ov});
   endtask

   task automatic step(input string tag, input logic [C-1:0] w, input logic [C*BW-1:0] d,
                       input logic r, input logic f);
      wr = w; in_s = d; rd = r; flush = f;
      @(posedge clk);
      model_edge(w, d, r, f);
      #1;
      check_all(tag);
      wr = '0; rd = 1'b0; flush = 1'b0;
   endtask

   typedef struct {
      logic [C-1:0] wr;
      logic         rd;
      logic         exp_ready;
      logic         exp_empty;
      logic         exp_ovld;
   } vec_t;

   vec_t            tbl [C+1];
   logic [C*BW-1:0] skew;

   initial begin
      for (int c = 0; c < C; c++) begin
         tbl[c].wr        = C'(1) << c;
         tbl[c].rd        = 1'b0;
         tbl[c].exp_ready = (c == C-1);
         tbl[c].exp_empty = 1'b0;
         tbl[c].exp_ovld  = 1'b0;
         skew[c*BW +: BW] = 16'h0100 + 16'(c);
      end
      tbl[C].wr = '0; tbl[C].rd = 1'b1;
      tbl[C].exp_ready = 1'b0; tbl[C].exp_empty = 1'b1; tbl[C].exp_ovld = 1'b1;

      reset = 1'b0; wr = '0; rd = 1'b0; flush = 1'b0; in_s = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      check_all("rst_init");

      // Reset mid-stream: three writes and a pop, then async reset.
      for (int k = 0; k < 3; k++) step("pre_rst", '1, rep(16'h0050 + 16'(k)), 1'b0, 1'b0);
      step("pre_rst_pop", '0, '0, 1'b1, 1'b0);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_all("rst_async");
      @(negedge clk) reset = 1'b1;
      step("rst_rd", '0, '0, 1'b1, 1'b0);

      // Skewed diagonal fill from the vector table.
      for (int i = 0; i <= C; i++) begin
         step("skew", tbl[i].wr, skew, tbl[i].rd, 1'b0);
         chk("tbl_ready", {127'b0, o_ready},   {127'b0, tbl[i].exp_ready});
         chk("tbl_empty", {127'b0, o_empty},   {127'b0, tbl[i].exp_empty});
         chk("tbl_ovld",  {127'b0, out_valid}, {127'b0, tbl[i].exp_ovld});
      end
      chk("skew_row", out, 128'h0107_0106_0105_0104_0103_0102_0101_0100);

      // Wrap-around: ten rows streamed through depth 4 with concurrent pops.
      for (int k = 0; k < 10; k++) begin
         step("wrap", '1, rep(16'(k)), 1'b1, 1'b0);
         if (k > 0) chk("wrap_row", out, rep(16'(k - 1)));
      end
      step("wrap_last", '0, '0, 1'b1, 1'b0);
      chk("wrap_row9", out, rep(16'd9));
      chk("wrap_ov", {127'b0, overflow}, 128'd0);

      // Full column 0 with a simultaneous pop and write.
      step("full_a", '1, rep(16'h0010), 1'b0, 1'b0);
      for (int k = 1; k < 4; k++) step("full_b", 8'h01, rep(16'h0010 + 16'(k)), 1'b0, 1'b0);
      step("full_rw", 8'h01, rep(16'hAAAA), 1'b1, 1'b0);
      chk("full_rw_full", {127'b0, o_full},   128'd1);
      chk("full_rw_ov",   {127'b0, overflow}, 128'd0);
      for (int k = 0; k < 4; k++) step("full_fill", 8'hFE, rep(16'h0020 + 16'(k)), 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) step("full_drain", '0, '0, 1'b1, 1'b0);
      chk("full_last", {112'b0, out[BW-1:0]}, {112'b0, 16'hAAAA});

      // Overflow on column 3, sticky until flush; flush blocks a pop.
      step("ov_a", '1, rep(16'h0030), 1'b0, 1'b0);
      for (int k = 1; k < 4; k++) step("ov_b", 8'h08, rep(16'h0030 + 16'(k)), 1'b0, 1'b0);
      step("ov_drop", 8'h08, rep(16'hDEAD), 1'b0, 1'b0);
      chk("ov_set",  {127'b0, overflow}, 128'd1);
      chk("ov_full", {127'b0, o_full},   128'd1);
      step("ov_hold", '0, '0, 1'b0, 1'b0);
      chk("ov_sticky", {127'b0, overflow}, 128'd1);
      step("ov_flush", '1, rep(16'h7777), 1'b1, 1'b1);
      chk("flush_ov",    {127'b0, overflow},  128'd0);
      chk("flush_empty", {127'b0, o_empty},   128'd1);
      chk("flush_ovld",  {127'b0, out_valid}, 128'd0);

      // Randomized traffic.
      for (int n = 0; n < 600; n++) begin
         logic [C-1:0]    w;
         logic [C*BW-1:0] d;
         w = C'($urandom);
         d = {$urandom, $urandom, $urandom, $urandom};
         step("rand", w, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/psum_ofifo.md
# psum_ofifo

Output collector directly downstream of the MAC array. Captures the per-column partial sums that emerge from the array's south edge, qualified by each column's valid bit, into `col` independent column FIFOs, since columns finish at skewed times. Releases one aligned row of `col` psums per read, once every column holds data. It feeds the accumulation/SFU stage and also serves as the drain buffer for output-stationary results.

## Interface
Parameters:
- `col`, 8, number of array columns (one FIFO each)
- `psum_bw`, 16, width of one partial sum
- `depth`, 64, entries per column FIFO; must be a power of 2 and ≥ 2

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in`  in  col*psum_bw  psums from the array south edge; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c]
- `wr`  in  col  per-column write strobe; driven by the array's per-column valid
- `rd`  in  1  pop request, applied to all columns together
- `flush`  in  1  synchronous clear of all FIFOs and flags
- `out`  out  col*psum_bw  registered popped row; same packing as `in`
- `out_valid`  out  1  `out` holds a newly popped row this cycle
- `o_ready`  out  1  every column count ≥ 1
- `o_full`  out  1  any column count == depth
- `o_empty`  out  1  every column count == 0
- `overflow`  out  1  sticky: a write hit a full column

## Operation
- Each column c has a circular buffer with write pointer, read pointer and a count of log2(depth)+1 bits.
- Pointers are log2(depth) bits wide and wrap naturally from depth-1 to 0.
- Write to column c: when `wr[c]` is 1 and `flush` is 0, store `in` slice c at the write pointer, then increment the pointer.
  - If the column is full and no pop occurs that cycle, drop the write. Pointer and count stay unchanged, and `overflow` is set.
- Pop: accepted only when `rd` is 1, `o_ready` is 1 and `flush` is 0.
  - Every column's read pointer increments together.
  - Each column's head entry is registered into `out`.
- `rd` with `o_ready` = 0 is ignored. `out` holds its value, `out_valid` = 0, and no flag changes.
- Write and pop on the same column in the same cycle:
  - Both take effect and the count is unchanged.
  - This holds when the column is full (the write is not dropped).
  - Because `o_ready` requires count ≥ 1, a write into an empty column is never visible to a pop in the same cycle.
- `flush` takes priority over `wr` and `rd` in the same cycle. It zeroes all pointers and counts and clears `overflow`. `out` keeps its value and `out_valid` = 0 in the next cycle.
- Columns are independent for writing. Column c may run ahead of others by up to depth entries.
- Outputs `o_ready`, `o_full` and `o_empty` are combinational decodes of the registered counts.

## Timing
- Reset (asynchronous assertion, release synchronous to `clk`) sets all pointers and counts to 0. Output values at reset:
  - `out` = 0
  - `out_valid` = 0
  - `overflow` = 0
  - `o_empty` = 1
  - `o_ready` = 0
  - `o_full` = 0
- Reset asserted mid-operation discards all stored data immediately; no drain occurs.
- Write-to-ready latency: a write at edge N raises that column's count after edge N. `o_ready` can go high in cycle N+1.
- Read latency is 1 cycle. With `rd` high while `o_ready` is high, sampled at edge N, `out` and `out_valid` = 1 update at edge N; both are visible during cycle N+1.
- Back-to-back pops: holding `rd` high gives one row per cycle while `o_ready` stays high.
- `out_valid` is a single-cycle pulse per accepted pop.
- Storage is flops or a simple register array; no memory read latency beyond the output register.

## Structure
- Shared package holds:
  - `PSUM_BW` and `COL` defaults, shared with the MAC array
  - a ceil-log2 function for pointer and count widths
- One sub-module, `psum_col_fifo`: a single-column FIFO with ports for write, pop, flush, full, empty, head data and a dropped-write pulse. It is generated `col` times.
- The top level does the following:
  - ANDs the per-column non-empty signals into `o_ready`
  - ORs the full signals into `o_full`
  - ORs the dropped-write pulses into the sticky `overflow`
  - registers `out` and `out_valid`

## Test plan
Parameters are col = 8, psum_bw = 16 and depth = 4 unless stated.
- Reset check: assert `reset` = 0 mid-stream after 3 writes, then release. Required: `o_empty` = 1, `o_ready` = 0, `out` = 0, `overflow` = 0, and `rd` has no effect.
- Skewed fill: write column c with value 16'h0100+c starting at cycle c (diagonal skew, one entry each). Required: `o_ready` rises only the cycle after column 7's write. `rd` then gives `out` = {16'h0107,…,16'h0100} with `out_valid` = 1 one cycle later; afterwards `o_empty` = 1.
- Wrap-around: push and pop 10 rows through depth 4, row k holding k in every column. Required: rows 0..9 appear in order and `overflow` stays 0.
- Full plus simultaneous access: fill column 0 to 4 entries and all other columns to 1. Pop while writing column 0 with 16'hAAAA. Required: column 0 count stays 4, `overflow` = 0, and 16'hAAAA appears as the last entry of column 0.
- Overflow: with column 3 holding 4 entries, write it once more without `rd`. Required: the write is dropped, `overflow` = 1 and sticky, and `o_full` = 1. Then `flush`. Required: `overflow` = 0, `o_empty` = 1, and `out_valid` = 0 even if `rd` was high in the flush cycle.
